// File: rtl/relin_combine_pkg.sv
// Types and constants for relin_combine, derived from the shared HE headers.
`include "he_headers.sv"

package relin_combine_pkg;
    localparam int BW            = `BIT_WIDTH;
    localparam int NUM_LANES     = `TILE_N;
    localparam int Q_MOD         = `_Q;
    localparam int DEF_NUM_TILES = `DEGREE_N / `TILE_N;

    typedef logic [NUM_LANES-1:0][BW-1:0] tile_t;

    typedef struct packed {
        tile_t d0;
        tile_t d1;
    } pair_t;
endpackage

// File: rtl/he_headers.sv
// Shared HE parameter definitions used across the relinearization datapath.
`ifndef HE_HEADERS_SV
`define HE_HEADERS_SV
`define BIT_WIDTH 8
`define TILE_N    4
`define DEGREE_N  16
`define _Q        97
`endif

// File: rtl/relin_combine_mod_add.sv
// Single-lane modular adder: (a + b) mod Q for operands already below Q.
module mod_add #(
    parameter int W = 8,
    parameter int Q = 97
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] s
);
    localparam logic [W:0] QW = (W+1)'(Q);

    logic [W:0] sum;

    always_comb begin
        sum = {1'b0, a} + {1'b0, b};
        s   = (sum >= QW) ? W'(sum - QW) : sum[W-1:0];
    end
endmodule

// File: rtl/relin_combine.sv
// Buffers tensor-product (d0,d1) tiles and adds each to the matching relin (c0,c1) tile.
module relin_combine
    import relin_combine_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int NUM_TILES  = DEF_NUM_TILES
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           d_valid_i,
    input  logic [NUM_LANES-1:0][BW-1:0]   d0_coeff_i,
    input  logic [NUM_LANES-1:0][BW-1:0]   d1_coeff_i,
    output logic                           d_ready_o,
    input  logic                           relin_valid_i,
    input  logic [NUM_LANES-1:0][BW-1:0]   relin_c0_i,
    input  logic [NUM_LANES-1:0][BW-1:0]   relin_c1_i,
    output logic                           valid_o,
    input  logic                           ready_i,
    output logic [NUM_LANES-1:0][BW-1:0]   ct0_coeff_o,
    output logic [NUM_LANES-1:0][BW-1:0]   ct1_coeff_o,
    output logic [$clog2(NUM_TILES)-1:0]   tile_idx_o,
    output logic                           done_o,
    output logic                           overflow_o,
    output logic                           underflow_o
);
    localparam int              PW       = $clog2(FIFO_DEPTH);
    localparam int              TW       = $clog2(NUM_TILES);
    localparam logic [PW:0]     FULL_CNT = (PW+1)'(FIFO_DEPTH);
    localparam logic [TW-1:0]   LAST_IDX = TW'(NUM_TILES - 1);

    pair_t         mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [PW:0]   count;
    logic          full, empty, slot_free, push, pop, xfer;
    pair_t         head;
    tile_t         sum0, sum1;

    assign full      = (count == FULL_CNT);
    assign empty     = (count == '0);
    assign slot_free = !valid_o || ready_i;
    assign pop       = relin_valid_i && !empty && slot_free;
    // A full FIFO still takes a pair in the cycle its head is popped.
    assign push      = !rst && d_valid_i && (!full || pop);
    assign d_ready_o = !rst && !full;
    assign xfer      = valid_o && ready_i;
    assign done_o    = !rst && xfer && (tile_idx_o == LAST_IDX);
    assign head      = mem[rd_ptr];

    for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
        mod_add #(.W(BW), .Q(Q_MOD)) u_add0 (.a(head.d0[l]), .b(relin_c0_i[l]), .s(sum0[l]));
        mod_add #(.W(BW), .Q(Q_MOD)) u_add1 (.a(head.d1[l]), .b(relin_c1_i[l]), .s(sum1[l]));
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {d0_coeff_i, d1_coeff_i};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            valid_o     <= 1'b0;
            ct0_coeff_o <= '0;
            ct1_coeff_o <= '0;
            tile_idx_o  <= '0;
            overflow_o  <= 1'b0;
            underflow_o <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;

            if (pop) begin
                valid_o     <= 1'b1;
                ct0_coeff_o <= sum0;
                ct1_coeff_o <= sum1;
            end else if (xfer) begin
                valid_o <= 1'b0;
            end

            if (xfer) tile_idx_o <= (tile_idx_o == LAST_IDX) ? '0 : tile_idx_o + 1'b1;

            // Relin tiles cannot be stalled, so a tile that has nowhere to go is lost.
            if (relin_valid_i && empty)               underflow_o <= 1'b1;
            if (relin_valid_i && !empty && !slot_free) overflow_o  <= 1'b1;
        end
    end
endmodule

// File: tb/tb_relin_combine.sv
// Directed scoreboard bench for relin_combine (Q=97, 4 lanes, 4 tiles per polynomial).
module tb_relin_combine;
    import relin_combine_pkg::*;

    localparam int NT = 4;

    typedef struct {
        tile_t ct0;
        tile_t ct1;
        int    idx;
    } exp_t;

    exp_t  sbq[$];
    int    errors  = 0;
    int    checks  = 0;
    int    exp_idx = 0;

    logic  clk = 0, rst = 1, d_valid_i = 0, relin_valid_i = 0, ready_i = 1;
    tile_t d0 = '0, d1 = '0, c0 = '0, c1 = '0;
    tile_t ct0, ct1;
    logic  d_ready_o, valid_o, done_o, overflow_o, underflow_o;
    logic [1:0] tile_idx_o;

    always #5 clk = ~clk;

    relin_combine #(.FIFO_DEPTH(4), .NUM_TILES(NT)) dut (
        .clk(clk), .rst(rst),
        .d_valid_i(d_valid_i), .d0_coeff_i(d0), .d1_coeff_i(d1), .d_ready_o(d_ready_o),
        .relin_valid_i(relin_valid_i), .relin_c0_i(c0), .relin_c1_i(c1),
        .valid_o(valid_o), .ready_i(ready_i),
        .ct0_coeff_o(ct0), .ct1_coeff_o(ct1), .tile_idx_o(tile_idx_o),
        .done_o(done_o), .overflow_o(overflow_o), .underflow_o(underflow_o)
    );

    function automatic tile_t mk(int a, int b, int c, int d);
        tile_t t;
        t[0] = BW'(a);
        t[1] = BW'(b);
        t[2] = BW'(c);
        t[3] = BW'(d);
        return t;
    endfunction

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_t(string name, tile_t act, tile_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_tile(tile_t e0, tile_t e1);
        exp_t e;
        e.ct0 = e0;
        e.ct1 = e1;
        e.idx = exp_idx;
        sbq.push_back(e);
        exp_idx = (exp_idx + 1) % NT;
    endtask

    task automatic push_pair(tile_t a, tile_t b);
        d_valid_i = 1;
        d0 = a;
        d1 = b;
        step();
        d_valid_i = 0;
    endtask

    // Monitor: compares every output transfer against the scoreboard head.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && valid_o && ready_i) begin
                if (sbq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_out: got tile %h idx %0d, expected none", ct0, tile_idx_o);
                end else begin
                    e = sbq.pop_front();
                    chk_t("ct0", ct0, e.ct0);
                    chk_t("ct1", ct1, e.ct1);
                    chk("tile_idx", int'(tile_idx_o), e.idx);
                    chk("done_at_xfer", int'(done_o), (e.idx == NT - 1) ? 1 : 0);
                end
            end else if (!rst) begin
                chk("done_idle", int'(done_o), 0);
            end
        end
    end

    initial begin
        step();
        chk("rst_valid", int'(valid_o), 0);
        chk("rst_d_ready", int'(d_ready_o), 0);
        chk("rst_done", int'(done_o), 0);
        chk("rst_idx", int'(tile_idx_o), 0);
        chk_t("rst_ct0", ct0, '0);
        chk_t("rst_ct1", ct1, '0);
        chk("rst_ovf", int'(overflow_o), 0);
        chk("rst_unf", int'(underflow_o), 0);
        rst = 0;
        step();
        chk("d_ready_after_rst", int'(d_ready_o), 1);

        // Basic combine, relin two cycles after the push
        push_pair(mk(10, 20, 30, 40), mk(10, 20, 30, 40));
        step();
        relin_valid_i = 1;
        c0 = mk(5, 5, 5, 5);
        c1 = mk(90, 80, 70, 60);
        expect_tile(mk(15, 25, 35, 45), mk(3, 3, 3, 3));
        step();
        relin_valid_i = 0;
        chk("latency1_valid", int'(valid_o), 1);
        chk("latency1_idx", int'(tile_idx_o), 0);
        step();

        // Three more tiles of the polynomial, back-to-back; idx 3 carries done
        push_pair(mk(1, 2, 3, 4), mk(50, 60, 70, 80));
        push_pair(mk(0, 0, 0, 0), mk(96, 96, 96, 96));
        push_pair(mk(48, 49, 0, 96), mk(11, 12, 13, 14));
        relin_valid_i = 1;
        c0 = mk(96, 95, 94, 93); c1 = mk(47, 36, 0, 17);
        expect_tile(mk(0, 0, 0, 0), mk(0, 96, 70, 0));
        step();
        c0 = mk(0, 1, 2, 3); c1 = mk(96, 1, 0, 50);
        expect_tile(mk(0, 1, 2, 3), mk(95, 0, 96, 49));
        step();
        c0 = mk(48, 48, 0, 0); c1 = mk(1, 2, 3, 4);
        expect_tile(mk(96, 0, 0, 96), mk(12, 14, 16, 18));
        step();
        relin_valid_i = 0;
        step();
        chk("idx_wrap", int'(tile_idx_o), 0);
        chk("valid_after_poly", int'(valid_o), 0);

        // Fill FIFO, then push and pop in the same cycle while full
        for (int k = 0; k < 4; k++) push_pair(mk(k, k, k, k), mk(k + 10, k + 10, k + 10, k + 10));
        chk("full_d_ready", int'(d_ready_o), 0);
        d_valid_i = 1;
        d0 = mk(4, 4, 4, 4);
        d1 = mk(14, 14, 14, 14);
        relin_valid_i = 1;
        c0 = mk(1, 1, 1, 1);
        c1 = mk(0, 0, 0, 0);
        expect_tile(mk(1, 1, 1, 1), mk(10, 10, 10, 10));
        step();
        d_valid_i = 0;
        chk("full_after_swap", int'(d_ready_o), 0);
        for (int k = 1; k <= 4; k++) begin
            expect_tile(mk(k + 1, k + 1, k + 1, k + 1), mk(k + 10, k + 10, k + 10, k + 10));
            step();
            if (k == 1) chk("d_ready_after_drain", int'(d_ready_o), 1);
        end
        relin_valid_i = 0;
        step();

        // Output stalled: a relin tile arriving now is dropped
        ready_i = 0;
        push_pair(mk(1, 1, 1, 1), mk(2, 2, 2, 2));
        push_pair(mk(7, 7, 7, 7), mk(8, 8, 8, 8));
        relin_valid_i = 1;
        c0 = mk(10, 20, 30, 40);
        c1 = mk(95, 95, 95, 95);
        expect_tile(mk(11, 21, 31, 41), mk(0, 0, 0, 0));
        step();
        c0 = mk(50, 50, 50, 50);
        step();
        relin_valid_i = 0;
        chk("overflow_set", int'(overflow_o), 1);
        chk("underflow_clear", int'(underflow_o), 0);
        chk("hold_valid", int'(valid_o), 1);
        chk_t("hold_ct0", ct0, mk(11, 21, 31, 41));
        step();
        chk_t("hold_ct0_2", ct0, mk(11, 21, 31, 41));
        chk_t("hold_ct1_2", ct1, mk(0, 0, 0, 0));
        ready_i = 1;
        relin_valid_i = 1;
        c0 = mk(90, 89, 88, 0);
        c1 = mk(0, 1, 2, 3);
        expect_tile(mk(0, 96, 95, 7), mk(8, 9, 10, 11));
        step();
        relin_valid_i = 0;
        step();
        chk("valid_after_drain", int'(valid_o), 0);

        // Relin with empty FIFO
        relin_valid_i = 1;
        step();
        relin_valid_i = 0;
        chk("underflow_set", int'(underflow_o), 1);
        chk("underflow_valid", int'(valid_o), 0);
        chk("overflow_sticky", int'(overflow_o), 1);
        step();
        chk("underflow_sticky", int'(underflow_o), 1);

        // Reset mid-polynomial with one tile in flight and one buffered
        ready_i = 0;
        push_pair(mk(3, 3, 3, 3), mk(3, 3, 3, 3));
        push_pair(mk(4, 4, 4, 4), mk(4, 4, 4, 4));
        relin_valid_i = 1;
        c0 = mk(1, 1, 1, 1);
        c1 = mk(1, 1, 1, 1);
        step();
        relin_valid_i = 0;
        rst = 1;
        step();
        chk("rst2_valid", int'(valid_o), 0);
        chk("rst2_idx", int'(tile_idx_o), 0);
        chk("rst2_ovf", int'(overflow_o), 0);
        chk("rst2_unf", int'(underflow_o), 0);
        chk("rst2_done", int'(done_o), 0);
        chk("rst2_d_ready", int'(d_ready_o), 0);
        rst = 0;
        ready_i = 1;
        exp_idx = 0;
        step();
        chk("rst2_d_ready_after", int'(d_ready_o), 1);
        relin_valid_i = 1;
        step();
        relin_valid_i = 0;
        chk("rst_discards_fifo", int'(underflow_o), 1);
        chk("rst_discards_valid", int'(valid_o), 0);

        push_pair(mk(40, 50, 60, 70), mk(1, 2, 3, 4));
        relin_valid_i = 1;
        c0 = mk(56, 50, 40, 30);
        c1 = mk(96, 96, 96, 96);
        expect_tile(mk(96, 3, 3, 3), mk(0, 1, 2, 3));
        step();
        relin_valid_i = 0;
        chk("post_rst_idx", int'(tile_idx_o), 0);
        step();
        step();
        chk("scoreboard_empty", sbq.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
